// File: rtl/mem_access_ctrl.sv
// Multicycle sequencer for data-memory loads and stores (byte/half/word).
// Sub-word stores use read-modify-write; misaligned or reserved-size requests finish at once with err.
module mem_access_ctrl #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        mdr_load,
    output logic [1:0]  ls_control,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_LOAD_CAP = 3'd2,
        S_MERGE    = 3'd3,
        S_WRITE    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        store_q, store_d;
    logic        err_q, err_d;
    logic        misaligned;

    assign misaligned = (size == 2'b11)
                      || (size == 2'b01 && addr[0])
                      || (size == 2'b10 && addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            store_q <= store_d;
            err_q   <= err_d;
        end
    end

    // wdata_q holds the store operand until MERGE overwrites it with the merged word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        store_d = store_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    size_d  = size;
                    store_d = is_store;
                    wdata_d = store_data;
                    err_d   = misaligned;
                    cnt_d   = 4'd0;
                    if (misaligned) begin
                        state_d = S_DONE;
                    end else if (is_store && size == 2'b10) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RD_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == LAT) begin
                    cnt_d   = 4'd0;
                    state_d = store_q ? S_MERGE : S_LOAD_CAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_LOAD_CAP: state_d = S_DONE;
            S_MERGE: begin
                if (size_q == 2'b00) begin
                    wdata_d = {mem_rdata[31:8], wdata_q[7:0]};
                end else begin
                    wdata_d = {mem_rdata[31:16], wdata_q[15:0]};
                end
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset clears them without a clock edge.
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign ls_control = size_q;
    assign mem_wr     = (state_q == S_WRITE);
    assign mdr_load   = (state_q == S_LOAD_CAP);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_DONE) && err_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multicycle sequencer for data-memory accesses (lb/lh/lw, sb/sh/sw) in the processor datapath.
- Drives memory address, write enable and write data, and the MDR load strobe. Supplies the 2-bit size select to the load-size extraction unit.
- Sub-word stores are done as read-modify-write: low byte/half replaced, upper bits kept.
- Checks alignment and reports misaligned accesses without touching memory.

Parameters:
MEM_LAT, 2, memory read latency in cycles from address valid to mem_rdata valid; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request strobe; accepted only when busy=0
is_store  in  1  1=store, 0=load; sampled with start
size  in  2  00=byte, 01=half, 10=word, 11=reserved; sampled with start
addr  in  32  byte address; sampled with start
store_data  in  32  store operand (low byte/half used for sb/sh); sampled with start
mem_rdata  in  32  memory read word; holds while mem_addr is stable
mem_addr  out  32  memory address (latched addr)
mem_wdata  out  32  memory write data
mem_wr  out  1  memory write enable, high exactly one cycle per store
mdr_load  out  1  MDR capture strobe, high exactly one cycle per load
ls_control  out  2  size select to the load-size unit = latched size
busy  out  1  high from the cycle after an accepted start through the DONE cycle
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with done on a rejected access

Behaviour:
- Reset (async, immediate): state=IDLE, latched fields=0, wait counter=0.
- Reset output values: mem_addr=0, mem_wdata=0, mem_wr=0, mdr_load=0, ls_control=00, busy=0, done=0, err=0.
- Reset mid-operation aborts the access at once; mem_wr drops without waiting for a clock edge.
- Start handling:
  - start with busy=0 in IDLE latches is_store, size, addr, store_data. Counting from the edge that samples start (cycle 0), the FSM moves as below.
  - start while busy=1 is ignored; latched fields are unchanged.
- Error check, performed on the start edge:
  - size=11 → error.
  - size=01 with addr[0]=1 → error.
  - size=10 with addr[1:0]≠00 → error.
  - Error path: → DONE with err=1. No mem_wr, no mdr_load.
- States:
  - IDLE: outputs idle, wait for start.
  - RD_WAIT: mem_wr=0, counter 1..MEM_LAT. Exit after MEM_LAT cycles: load → LOAD_CAP; sub-word store → MERGE.
  - LOAD_CAP: mdr_load=1 for one cycle → DONE.
  - MERGE: form the write word from mem_rdata.
    - sb: mem_wdata = {mem_rdata[31:8], store_data[7:0]}.
    - sh: mem_wdata = {mem_rdata[31:16], store_data[15:0]}.
    - Then → WRITE.
  - WRITE: mem_wr=1 for one cycle with mem_wdata stable → DONE.
  - DONE: done=1 (plus err when flagged), busy=1 → IDLE.
- Path selection from IDLE on an accepted start:
  - Load: → RD_WAIT.
  - sw: → WRITE directly, mem_wdata=store_data.
  - sb/sh: → RD_WAIT.
- Latency, start edge to done cycle:
  - lw/lh/lb: MEM_LAT+2.
  - sw: 2.
  - sb/sh: MEM_LAT+3.
  - error: 1.
- Ordering and stability:
  - Back-to-back: start may be accepted in the IDLE cycle following DONE; a start during DONE is ignored.
  - mem_addr is held constant from cycle 1 to the end of DONE.
  - ls_control changes only on an accepted start.
- Width/arithmetic: no address increment and no wrap. mem_addr=0xFFFFFFFC for a word access is legal.

Test Plan:
- lw, MEM_LAT=2, addr=0x00000010, mem_rdata=0xDEADBEEF → mdr_load high in cycle 3, ls_control=10, done in cycle 4, mem_wr never high.
- sw addr=0x00000020, store_data=0x12345678 → mem_wr high only in cycle 1 with mem_wdata=0x12345678 and mem_addr=0x20, done in cycle 2.
- sb addr=0x00000024, store_data=0x000000AB, mem_rdata=0x11223344 → mem_wr in cycle 4 with mem_wdata=0x112233AB, done in cycle 5. Repeat as sh with store_data=0x0000CDEF → mem_wdata=0x1122CDEF.
- Misaligned lw addr=0x00000002, then size=11 → each: done=err=1 in cycle 1, no mem_wr/mdr_load, busy falls next cycle.
- Second start pulses during busy with different addr → ignored, mem_addr unchanged. Start in the first IDLE cycle after done → accepted.
- Assert reset during WRITE of a store and during RD_WAIT of a load → all outputs 0 immediately (before next edge), state IDLE, next start behaves normally.
